// File: rtl/yuv_mcu_sequencer.sv
// yuv_mcu_sequencer: drains one 4:2:0 MCU from the IDCT buffers through the
// non-stallable colour converter into a backpressured RGB output FIFO.
module yuv_mcu_sequencer #(
    parameter int Y_PRECISION  = 8,
    parameter int R_PRECISION  = 8,
    parameter int CONV_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                   i_sysclk,
    input  logic                   i_arstn,
    input  logic                   i_mcu_valid,
    output logic                   o_mcu_done,
    output logic                   o_rd_en,
    output logic [7:0]             o_y_addr,
    output logic [5:0]             o_c_addr,
    input  logic [Y_PRECISION-1:0] i_Y,
    input  logic [Y_PRECISION-1:0] i_U,
    input  logic [Y_PRECISION-1:0] i_V,
    output logic [Y_PRECISION-1:0] o_Y,
    output logic [Y_PRECISION-1:0] o_U,
    output logic [Y_PRECISION-1:0] o_V,
    input  logic [R_PRECISION-1:0] i_R,
    input  logic [R_PRECISION-1:0] i_G,
    input  logic [R_PRECISION-1:0] i_B,
    output logic                   o_pix_valid,
    input  logic                   i_pix_ready,
    output logic [R_PRECISION-1:0] o_R,
    output logic [R_PRECISION-1:0] o_G,
    output logic [R_PRECISION-1:0] o_B,
    output logic                   o_last,
    output logic                   o_busy
);
    localparam int PIPE = 2 + CONV_LATENCY;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = 3 * R_PRECISION + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      pix_q, pix_d;
    logic [PIPE-1:0] vld_q, lst_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_q, rd_q;
    logic [PW-1:0]   mem_q [FIFO_DEPTH];
    logic            push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE; i++) inflight = inflight + CW'(vld_q[i]);
    end

    // Reads are throttled so every pixel in flight already owns a FIFO slot.
    assign o_rd_en  = (state_q == RUN) &&
                      (({1'b0, cnt_q} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH));
    assign o_y_addr = pix_q;
    assign o_c_addr = {pix_q[7:5], pix_q[3:1]};
    assign o_busy     = state_q != IDLE;
    assign o_mcu_done = state_q == DONE;

    assign push        = vld_q[PIPE-1];
    assign o_pix_valid = cnt_q != '0;
    assign pop         = o_pix_valid && i_pix_ready;
    assign cnt_d       = cnt_q + CW'(push) - CW'(pop);
    assign {o_last, o_R, o_G, o_B} = o_pix_valid ? mem_q[rd_q] : '0;

    always_comb begin
        state_d = state_q;
        pix_d   = o_rd_en ? pix_q + 8'd1 : pix_q;
        unique case (state_q)
            IDLE:    state_d = i_mcu_valid ? RUN : IDLE;
            RUN:     state_d = (o_rd_en && pix_q == 8'd255) ? DRAIN : RUN;
            DRAIN:   state_d = (vld_q == '0) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q <= IDLE;
            pix_q   <= '0;
            vld_q   <= '0;
            lst_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            o_Y     <= '0;
            o_U     <= '0;
            o_V     <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            vld_q   <= {vld_q[PIPE-2:0], o_rd_en};
            lst_q   <= {lst_q[PIPE-2:0], o_rd_en && pix_q == 8'd255};
            cnt_q   <= cnt_d;
            if (vld_q[0]) begin
                o_Y <= i_Y;
                o_U <= i_U;
                o_V <= i_V;
            end
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (push) mem_q[wr_q] <= {lst_q[PIPE-1], i_R, i_G, i_B};
    end
endmodule

// File: doc/yuv_mcu_sequencer.md
Name: yuv_mcu_sequencer

Overview:
- Drains one decoded 4:2:0 MCU (16x16 Y, 8x8 U, 8x8 V) from the IDCT output buffers into the yuv_to_rgb converter in raster order.
- Tracks pixels in flight through the non-stallable converter pipeline.
- Buffers converted RGB pixels in a small output FIFO with valid/ready backpressure toward the frame writer.
- Releases the MCU buffer once every pixel has left the converter.

Parameters:
Y_PRECISION, 8, Y/U/V sample width
R_PRECISION, 8, R/G/B width
CONV_LATENCY, 2, cycles from converter input change to matching output; must equal the instantiated converter
FIFO_DEPTH, 8, output FIFO entries, power of 2, >= CONV_LATENCY+4

Ports:
i_sysclk  in  1  system clock
i_arstn  in  1  asynchronous active-low reset
i_mcu_valid  in  1  level: an MCU is complete in the buffers
o_mcu_done  out  1  1-cycle pulse: MCU buffer released
o_rd_en  out  1  buffer read strobe
o_y_addr  out  8  Y buffer address {row[3:0],col[3:0]}
o_c_addr  out  6  U/V buffer address {row[3:1],col[3:1]}
i_Y, i_U, i_V  in  Y_PRECISION each  buffer data, valid 1 cycle after o_rd_en
o_Y, o_U, o_V  out  Y_PRECISION each  registered converter inputs
i_R, i_G, i_B  in  R_PRECISION each  converter outputs
o_pix_valid  out  1  FIFO head valid
i_pix_ready  in  1  downstream accepts head
o_R, o_G, o_B  out  R_PRECISION each  FIFO head pixel
o_last  out  1  head is pixel 255 of the MCU
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async on i_arstn low): all outputs 0, FSM IDLE, pixel counter 0, FIFO empty, in-flight pipe cleared. Any MCU in progress is abandoned. After release, the next start begins at pixel 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN when i_mcu_valid=1.
  - RUN -> DRAIN on the cycle pixel 255 is issued.
  - DRAIN -> DONE when the in-flight count is 0 and the last pixel has been written to the FIFO.
  - DONE -> IDLE unconditionally. o_mcu_done=1 only in DONE. i_mcu_valid is ignored in DONE.
- Issue rule: in RUN, o_rd_en=1 iff fifo_count + inflight_count < FIFO_DEPTH. Both counts are sampled this cycle; a same-cycle pop is not credited.
- On issue, the pixel counter p (0..255) increments. col=p[3:0], row=p[7:4]. Addresses are valid with o_rd_en.
- Pipeline for a read issued at cycle t:
  - t+1: i_Y/U/V valid.
  - t+2: o_Y/U/V registered.
  - t+2+CONV_LATENCY: i_R/G/B sampled and pushed to the FIFO together with the last flag (p==255).
- In-flight tracking: a valid+last shift register of length 2+CONV_LATENCY. inflight_count = number of set valid bits.
- o_Y/U/V hold their last value when no read is in flight. The converter sees stable inputs; outputs are not pushed.
- FIFO: show-ahead. o_pix_valid = !empty. Pop when o_pix_valid & i_pix_ready. Simultaneous push and pop keeps the count unchanged.
- By construction the FIFO never overflows. A push while full is a design error; the bench flags it.
- With i_pix_ready held high, throughput is 1 pixel/cycle. Back-to-back MCUs add 2 idle issue cycles (DONE, IDLE).
- o_mcu_done occurs only after all 256 pixels are in the FIFO, not necessarily after they are consumed.

Test Plan:
- Reset: hold i_arstn=0, toggle inputs -> all outputs 0, o_busy=0. After release with i_mcu_valid=0 for 20 cycles -> no o_rd_en.
- Single MCU, real yuv_to_rgb instance, i_pix_ready=1, Y[a]=a, U=V=128:
  - exactly 256 pixels in order, o_last only on the 256th;
  - p=53 (row 3, col 5) -> o_y_addr=53, o_c_addr=10;
  - first o_pix_valid at 3+CONV_LATENCY cycles after the first o_rd_en;
  - o_mcu_done pulses once.
- Colour check: buffer entries (76,84,255), (149,43,21), (29,255,107) -> RGB ~(255,0,0), (0,255,0), (0,0,255).
- Backpressure: i_pix_ready=0 for 50 cycles mid-MCU ->
  - o_rd_en stops with fifo_count+inflight_count <= 8;
  - no FIFO overflow;
  - after resume, all 256 pixels arrive with no loss or duplication.
- Back-to-back: i_mcu_valid held high across two MCUs -> second MCU's first o_rd_en is exactly 2 cycles after o_mcu_done. 512 pixels total, with o_last at 256 and 512.
- Mid-MCU reset at pixel 100 -> outputs clear immediately. After release, the next MCU begins with o_y_addr=0, and no stale pixels appear.
